// File: rtl/m_seq_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// m_seq_pkg
// Shared constants for the m-sequence code generator and its neighbours.
//   MIN_ORDER / MAX_ORDER : supported LFSR lengths.
//   SYMBOL_CLK_DIV        : default clk cycles per code bit (50 MHz -> 1 kbit/s),
//                           shared with the modulator stages.
//   tap_mask(order)       : Fibonacci feedback taps for a maximal-length LFSR,
//                           bit k-1 set for polynomial tap k.
// -----------------------------------------------------------------------------
package m_seq_pkg;

   localparam int MIN_ORDER      = 3;
   localparam int MAX_ORDER      = 10;
   localparam int SYMBOL_CLK_DIV = 50000;

   function automatic logic [MAX_ORDER-1:0] tap_mask(input int order);
      case (order)
         3:       tap_mask = 10'h006;   // {3,2}
         4:       tap_mask = 10'h00C;   // {4,3}
         5:       tap_mask = 10'h014;   // {5,3}
         6:       tap_mask = 10'h030;   // {6,5}
         7:       tap_mask = 10'h060;   // {7,6}
         8:       tap_mask = 10'h0B8;   // {8,6,5,4}
         9:       tap_mask = 10'h110;   // {9,5}
         10:      tap_mask = 10'h240;   // {10,7}
         default: tap_mask = '0;
      endcase
   endfunction

endpackage

// File: rtl/m_seq_code_gen_clk_en_div.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_en_div
// Symbol-rate clock-enable divider. Counts enabled clk cycles 0..CLK_DIV-1 and
// raises tick combinationally in the last enabled cycle of each period, so the
// consumer acts on the same edge that wraps the counter.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (counter -> 0)
//   en    : count enable; the count holds while low
//   clr   : synchronous clear, wins over en and suppresses tick
//   tick  : one-cycle enable for the symbol-rate logic
// -----------------------------------------------------------------------------
module clk_en_div #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = en & ~clr & (div_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (clr) begin
         div_cnt <= '0;
      end else if (en) begin
         if (div_cnt == LAST) div_cnt <= '0;
         else                 div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/m_seq_code_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// m_seq_code_gen
// Serial m-sequence (PN) code source for the ASK modulator. A Fibonacci LFSR
// advances once per symbol period set by clk_en_div.
// Build option: define M_SEQ_DIFF_CODE_EN to differentially encode the output
// (running XOR of the raw LFSR bits, 0 after reset/load) for a DPSK stage.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : run enable for divider and LFSR
//   load, seed_in   : synchronous seed load (zero seed becomes all-ones)
//   m_ser_code_out  : registered serial code bit
//   bit_strobe      : one-cycle pulse on each shift
//   frame_sync      : bit_strobe on the first bit of each sequence period
//   lfsr_state      : current LFSR register
// -----------------------------------------------------------------------------
module m_seq_code_gen
   import m_seq_pkg::*;
#(
   parameter int                    CLK_DIV    = SYMBOL_CLK_DIV,
   parameter int                    LFSR_ORDER = 7,
   parameter logic [LFSR_ORDER-1:0] SEED       = '1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  load,
   input  logic [LFSR_ORDER-1:0] seed_in,
   output logic                  m_ser_code_out,
   output logic                  bit_strobe,
   output logic                  frame_sync,
   output logic [LFSR_ORDER-1:0] lfsr_state
);

   localparam int                   N           = LFSR_ORDER;
   localparam logic [MAX_ORDER-1:0] TAPS_FULL   = tap_mask(N);
   localparam logic [N-1:0]         TAPS        = TAPS_FULL[N-1:0];
   // Period counter runs 0..2^N-2, one count per bit of the sequence.
   localparam logic [N-1:0]         PERIOD_LAST = N'((1 << N) - 2);

   logic         tick;
   logic [N-1:0] state;
   logic [N-1:0] next_state;
   logic [N-1:0] load_val;
   logic [N-1:0] period_cnt;
   logic [N-1:0] period_nxt;
   logic         code_shift;
   logic         code_load;

   clk_en_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_en_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (load),
      .tick  (tick)
   );

`ifdef M_SEQ_DIFF_CODE_EN
   localparam logic RST_CODE = 1'b0;
`else
   localparam logic RST_CODE = SEED[N-1];
`endif

   always_comb begin
      // All-zero is the LFSR's dead state; jump out to all-ones.
      if (state == '0) next_state = '1;
      else             next_state = {state[N-2:0], ^(state & TAPS)};

      load_val   = (seed_in == '0) ? '1 : seed_in;
      period_nxt = (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;

`ifdef M_SEQ_DIFF_CODE_EN
      // The output register doubles as the differential history bit.
      code_shift = m_ser_code_out ^ next_state[N-1];
      code_load  = 1'b0;
`else
      code_shift = next_state[N-1];
      code_load  = load_val[N-1];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= SEED;
         m_ser_code_out <= RST_CODE;
         period_cnt     <= '0;
         bit_strobe     <= 1'b0;
         frame_sync     <= 1'b0;
      end else if (load) begin
         state          <= load_val;
         m_ser_code_out <= code_load;
         period_cnt     <= '0;
         bit_strobe     <= 1'b0;
         frame_sync     <= 1'b0;
      end else if (tick) begin
         state          <= next_state;
         m_ser_code_out <= code_shift;
         period_cnt     <= period_nxt;
         bit_strobe     <= 1'b1;
         frame_sync     <= (period_nxt == '0);
      end else begin
         bit_strobe     <= 1'b0;
         frame_sync     <= 1'b0;
      end
   end

   assign lfsr_state = state;

endmodule

// File: tb/tb_m_seq_code_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_m_seq_code_gen
// Two instances: order 3 / CLK_DIV 4 / SEED 001, and order 7 / CLK_DIV 1.
// Expected shifts are pushed to a queue as stimulus is applied and popped when
// the DUT strobes. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_m_seq_code_gen;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en3, load3, code3, strobe3, fs3;
   logic [2:0] seed3, state3;
   logic       en7, load7, code7, strobe7, fs7;
   logic [6:0] seed7, state7;

   m_seq_code_gen #(.CLK_DIV(4), .LFSR_ORDER(3), .SEED(3'b001)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .load(load3), .seed_in(seed3),
      .m_ser_code_out(code3), .bit_strobe(strobe3), .frame_sync(fs3),
      .lfsr_state(state3)
   );

   m_seq_code_gen #(.CLK_DIV(1), .LFSR_ORDER(7), .SEED(7'h7F)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .en(en7), .load(load7), .seed_in(seed7),
      .m_ser_code_out(code7), .bit_strobe(strobe7), .frame_sync(fs7),
      .lfsr_state(state7)
   );

   // ---------------- scoreboard / model ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   logic [4:0] exp_q[$];   // {frame_sync, code, state}
   logic [2:0] m_state;
   logic [2:0] m_pcnt;
   logic       m_d;

`ifdef M_SEQ_DIFF_CODE_EN
   localparam logic DIFF = 1'b1;
`else
   localparam logic DIFF = 1'b0;
`endif

   function automatic logic [2:0] step3(input logic [2:0] s);
      if (s == 3'b000) return 3'b111;
      return {s[1:0], s[2] ^ s[1]};
   endfunction

   function automatic logic [6:0] step7(input logic [6:0] s);
      if (s == 7'h00) return 7'h7F;
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   // Code bit expected while idle (after reset/load or holding).
   function automatic logic idle_code3();
      return DIFF ? m_d : m_state[2];
   endfunction

   task automatic model_reset();
      m_state = 3'b001; m_pcnt = 3'd0; m_d = 1'b0;
   endtask

   task automatic model_load(input logic [2:0] s);
      m_state = (s == 3'b000) ? 3'b111 : s;
      m_pcnt  = 3'd0;
      m_d     = 1'b0;
      if (!DIFF) m_d = m_state[2];
   endtask

   task automatic push_model_shift();
      logic raw;
      m_state = step3(m_state);
      m_pcnt  = (m_pcnt == 3'd6) ? 3'd0 : m_pcnt + 3'd1;
      raw     = m_state[2];
      m_d     = DIFF ? (m_d ^ raw) : raw;
      exp_q.push_back({(m_pcnt == 3'd0), m_d, m_state});
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_strobe3(output int cycles, output bit ok);
      ok = 1'b0;
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cycles++;
         if (strobe3) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_shift3(input int exp_cycles, input string name);
      int         cyc;
      bit         ok;
      logic [4:0] exp;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bxxxxx;
      wait_strobe3(cyc, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL %s timeout: no bit_strobe within 40 cycles", name);
         return;
      end
      tests_run++;
      if (cyc != exp_cycles) begin
         tests_failed++;
         $display("FAIL %s spacing: got %0d cycles, expected %0d", name, cyc, exp_cycles);
      end
      tests_run++;
      if ({fs3, code3, state3} !== exp) begin
         tests_failed++;
         $display("FAIL %s shift: got fs=%b code=%b state=%b, expected fs=%b code=%b state=%b",
                  name, fs3, code3, state3, exp[4], exp[3], exp[2:0]);
      end
      tests_run++;
      if (state3 == 3'b000) begin
         tests_failed++;
         $display("FAIL %s lockup: state reached 000", name);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      en3 = 1'b0; load3 = 1'b0; seed3 = 3'b000;
      en7 = 1'b0; load7 = 1'b0; seed7 = 7'h00;
      repeat (3) @(negedge clk);
      model_reset();
      tests_run++;
      if ({fs3, strobe3, code3, state3} !== {1'b0, 1'b0, 1'b0, 3'b001}) begin
         tests_failed++;
         $display("FAIL reset3: got fs=%b strobe=%b code=%b state=%b, expected 0 0 0 001",
                  fs3, strobe3, code3, state3);
      end
      tests_run++;
      if ({fs7, strobe7, code7, state7} !== {1'b0, 1'b0, ~DIFF, 7'h7F}) begin
         tests_failed++;
         $display("FAIL reset7: got fs=%b strobe=%b code=%b state=%h, expected 0 0 %b 7f",
                  fs7, strobe7, code7, state7, ~DIFF);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sequence();
      logic [2:0] seq_s [7] = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
      logic       seq_b [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       d;
      d = 1'b0;
      for (int i = 0; i < 7; i++) begin
         d = DIFF ? (d ^ seq_b[i]) : seq_b[i];
         exp_q.push_back({(i == 6), d, seq_s[i]});
      end
      m_state = 3'b001; m_pcnt = 3'd0; m_d = d;
      en3 = 1'b1;
      for (int i = 0; i < 7; i++) check_shift3(4, "sequence");
   endtask

   task automatic test_enable_hold();
      bit bad;
      repeat (2) @(negedge clk);        // div_cnt now 2
      en3 = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (strobe3 || fs3 || state3 !== m_state || code3 !== idle_code3()) bad = 1'b1;
      end
      tests_run++;
      if (bad) begin
         tests_failed++;
         $display("FAIL hold: outputs moved while en=0 (state=%b code=%b), expected state=%b code=%b",
                  state3, code3, m_state, idle_code3());
      end
      en3 = 1'b1;
      push_model_shift();
      check_shift3(2, "resume");
   endtask

   task automatic test_load();
      @(negedge clk);
      load3 = 1'b1; seed3 = 3'b110;
      @(negedge clk);
      load3 = 1'b0;
      model_load(3'b110);
      tests_run++;
      if ({fs3, strobe3, code3, state3} !== {1'b0, 1'b0, ~DIFF, 3'b110}) begin
         tests_failed++;
         $display("FAIL load: got fs=%b strobe=%b code=%b state=%b, expected 0 0 %b 110",
                  fs3, strobe3, code3, state3, ~DIFF);
      end
      for (int i = 0; i < 7; i++) push_model_shift();
      for (int i = 0; i < 7; i++) check_shift3(4, "after_load");
   endtask

   task automatic test_zero_seed();
      @(negedge clk);
      load3 = 1'b1; seed3 = 3'b000;
      @(negedge clk);
      load3 = 1'b0;
      model_load(3'b000);
      tests_run++;
      if (state3 !== 3'b111) begin
         tests_failed++;
         $display("FAIL zero_seed: got state=%b, expected 111", state3);
      end
      for (int i = 0; i < 20; i++) push_model_shift();
      for (int i = 0; i < 20; i++) check_shift3(4, "zero_seed");
   endtask

   task automatic test_reset_mid();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      tests_run++;
      if ({fs3, strobe3, code3, state3} !== {1'b0, 1'b0, 1'b0, 3'b001}) begin
         tests_failed++;
         $display("FAIL reset_mid: got fs=%b strobe=%b code=%b state=%b, expected 0 0 0 001",
                  fs3, strobe3, code3, state3);
      end
      @(negedge clk);
      rst_n = 1'b1;
      push_model_shift();
      check_shift3(4, "post_reset");
      en3 = 1'b0;
   endtask

   task automatic test_fast_order7();
      logic [8:0] exp7_q[$];
      logic [8:0] e;
      logic [6:0] s;
      logic [6:0] p;
      logic       d;
      int         ones, m_ones, fs_first, fs_second, mism;
      bit         strobe_gap;
      s = 7'h7F; p = 7'd0; d = 1'b0;
      ones = 0; m_ones = 0; fs_first = -1; fs_second = -1; mism = 0; strobe_gap = 1'b0;
      @(negedge clk);
      en7 = 1'b1;
      for (int c = 1; c <= 254; c++) begin
         s = step7(s);
         p = (p == 7'd126) ? 7'd0 : p + 7'd1;
         d = DIFF ? (d ^ s[6]) : s[6];
         exp7_q.push_back({(p == 7'd0), d, s});
         @(negedge clk);
         e = exp7_q.pop_front();
         if ({fs7, code7, state7} !== e) mism++;
         if (!strobe7) strobe_gap = 1'b1;
         if (c <= 127) begin
            if (code7) ones++;
            if (e[7])  m_ones++;
         end
         if (fs7 && fs_first < 0)                 fs_first = c;
         else if (fs7 && fs_second < 0)           fs_second = c;
      end
      en7 = 1'b0;
      tests_run++;
      if (strobe_gap) begin
         tests_failed++;
         $display("FAIL fast_strobe: bit_strobe dropped low with CLK_DIV=1, expected continuous high");
      end
      tests_run++;
      if (mism != 0) begin
         tests_failed++;
         $display("FAIL fast_stream: %0d cycles differ from model, expected 0", mism);
      end
      tests_run++;
      if (ones != (DIFF ? m_ones : 64)) begin
         tests_failed++;
         $display("FAIL fast_ones: got %0d ones in 127 bits, expected %0d", ones, DIFF ? m_ones : 64);
      end
      tests_run++;
      if (fs_first != 127 || fs_second != 254) begin
         tests_failed++;
         $display("FAIL fast_frame: frame_sync at cycles %0d,%0d, expected 127,254", fs_first, fs_second);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence / report ----------------
   initial begin
      test_reset();
      test_sequence();
      test_enable_hold();
      test_load();
      test_zero_seed();
      test_reset_mid();
      test_fast_order7();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
